// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Front end for the lab ALU. Two button presses load operand A and then
//   operand B (with carry-in and op select) from the board switches. The
//   operands are held steady while a fixed settle window covers the clocked
//   multiplier. The ALU result and flags are then captured and held for
//   display until the next press.
//
// Parameters
//   N            operand/result width (>= 2)
//   WAIT_CYCLES  settle edges between the B load and the capture (>= 1)
//
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   btn           raw load button (debounced, asynchronous to clk)
//   sw, cin_sw    operand switches and carry-in switch
//   op            operation select switches
//   alu_y         ALU result after the downstream op mux
//   alu_flags     {Z,N,C,V} after the downstream op mux
//   A, B, Cin     held operands / carry-in
//   shift_amount  B[$clog2(N):0], unclamped
//   op_q          held op select, drives the downstream mux
//   result, flags captured ALU outputs
//   state         current FSM state (S_A=0, S_B=1, S_WAIT=2, S_SHOW=3)
//   done          one-cycle pulse in the first S_SHOW cycle
module alu_operand_sequencer #(
    parameter int N           = 4,
    parameter int WAIT_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn,
    input  logic [N-1:0]         sw,
    input  logic                 cin_sw,
    input  logic [3:0]           op,
    input  logic [N-1:0]         alu_y,
    input  logic [3:0]           alu_flags,
    output logic [N-1:0]         A,
    output logic [N-1:0]         B,
    output logic                 Cin,
    output logic [$clog2(N):0]   shift_amount,
    output logic [3:0]           op_q,
    output logic [N-1:0]         result,
    output logic [3:0]           flags,
    output logic [1:0]           state,
    output logic                 done
);

    localparam int SW_HI = $clog2(N);
    localparam int CW    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_WAIT = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t        cur, nxt;
    logic          sync1, sync2, prev;
    logic          press;
    logic [CW-1:0] cnt;
    logic          ld_a, ld_b, cap;

    // Two-flop synchronizer plus a delay flop for rising-edge detection,
    // so a held button yields exactly one press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_A;
        else      cur <= nxt;
    end

    // Next-state logic; presses during S_WAIT simply fall through.
    always_comb begin
        nxt = cur;
        case (cur)
            S_A:     if (press) nxt = S_B;
            S_B:     if (press) nxt = S_WAIT;
            S_WAIT:  if (cnt == CNT_LAST) nxt = S_SHOW;
            S_SHOW:  if (press) nxt = S_A;
            default: nxt = S_A;
        endcase
    end

    // Datapath strobes decoded from the state
    always_comb begin
        ld_a = (cur == S_A) && press;
        ld_b = (cur == S_B) && press;
        cap  = (cur == S_WAIT) && (cnt == CNT_LAST);
    end

    // Operand, counter and capture registers. Each register only moves on its
    // own strobe, so the ALU inputs stay glitch-free through the settle window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A      <= '0;
            B      <= '0;
            Cin    <= 1'b0;
            op_q   <= 4'd0;
            cnt    <= '0;
            result <= '0;
            flags  <= 4'd0;
            done   <= 1'b0;
        end else begin
            if (ld_a) A <= sw;
            if (ld_b) begin
                B    <= sw;
                Cin  <= cin_sw;
                op_q <= op;
                cnt  <= '0;
            end else if (cur == S_WAIT && !cap) begin
                cnt <= cnt + CW'(1);
            end
            if (cap) begin
                result <= alu_y;
                flags  <= alu_flags;
            end
            // High only for the cycle after the capture edge.
            done <= cap;
        end
    end

    assign shift_amount = B[SW_HI:0];
    assign state        = cur;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    localparam int N1 = 4;
    localparam int W1 = 8;
    localparam int N2 = 8;
    localparam int W2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: N=4, WAIT_CYCLES=8
    logic              rst1, btn1, cin1;
    logic [N1-1:0]     sw1, y1;
    logic [3:0]        op1, fl_in1;
    logic [N1-1:0]     a1, b1, result1;
    logic              c1, done1;
    logic [$clog2(N1):0] sh1;
    logic [3:0]        opq1, flags1;
    logic [1:0]        state1;

    // DUT 2: N=8, WAIT_CYCLES=1
    logic              rst2, btn2, cin2;
    logic [N2-1:0]     sw2, y2;
    logic [3:0]        op2, fl_in2;
    logic [N2-1:0]     a2, b2, result2;
    logic              c2, done2;
    logic [$clog2(N2):0] sh2;
    logic [3:0]        opq2, flags2;
    logic [1:0]        state2;

    alu_operand_sequencer #(.N(N1), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst1), .btn(btn1), .sw(sw1), .cin_sw(cin1), .op(op1),
        .alu_y(y1), .alu_flags(fl_in1), .A(a1), .B(b1), .Cin(c1),
        .shift_amount(sh1), .op_q(opq1), .result(result1), .flags(flags1),
        .state(state1), .done(done1)
    );

    alu_operand_sequencer #(.N(N2), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .rst(rst2), .btn(btn2), .sw(sw2), .cin_sw(cin2), .op(op2),
        .alu_y(y2), .alu_flags(fl_in2), .A(a2), .B(b2), .Cin(c2),
        .shift_amount(sh2), .op_q(opq2), .result(result2), .flags(flags2),
        .state(state2), .done(done2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise btn; the load happens on the third edge. btn is left high.
    task automatic press_hold1();
        btn1 = 1'b1;
        repeat (3) step();
    endtask

    task automatic press_hold2();
        btn2 = 1'b1;
        repeat (3) step();
    endtask

    task automatic release1();
        btn1 = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_zero1(input string tag);
        check({tag, "_A"}, a1, 0);
        check({tag, "_B"}, b1, 0);
        check({tag, "_Cin"}, c1, 0);
        check({tag, "_sh"}, sh1, 0);
        check({tag, "_opq"}, opq1, 0);
        check({tag, "_res"}, result1, 0);
        check({tag, "_flags"}, flags1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_state"}, state1, 0);
    endtask

    // Step until done1 is seen (bounded), then check edge count and scoreboard.
    task automatic wait_capture1(input int w);
        int  k;
        bit  seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < w + 4) begin
            step();
            k++;
            if (done1) seen = 1'b1;
            else check("wait_state", state1, 2);
        end
        check("capture_edge", k, w);
        check("show_state", state1, 3);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            last_exp = sb_q.pop_front();
            check("capture_val", {flags1, result1}, last_exp);
        end
        step();
        check("done_pulse", done1, 0);
        check("held_val", {flags1, result1}, last_exp);
    endtask

    initial begin
        int trans;
        logic [1:0] prev_s;
        logic [N1-1:0] a_keep;

        rst1 = 1'b0; rst2 = 1'b0;
        btn2 = 1'b0; sw2 = '0; cin2 = 1'b0; op2 = '0; y2 = '0; fl_in2 = '0;
        // Reset with random inputs on DUT 1
        for (int i = 0; i < 4; i++) begin
            btn1 = 1'($urandom); sw1 = N1'($urandom); cin1 = 1'($urandom);
            op1 = 4'($urandom); y1 = N1'($urandom); fl_in1 = 4'($urandom);
            step();
            check("rst_state", state1, 0);
        end
        check_zero1("rst");
        btn1 = 1'b0;
        step();
        rst1 = 1'b1; rst2 = 1'b1;
        repeat (3) step();
        check_zero1("post_rst");

        // Full SUB sequence
        sw1 = 4'd9;
        press_hold1();
        check("a_load", a1, 9);
        check("a_state", state1, 1);
        release1();
        sw1 = 4'd3; cin1 = 1'b1; op1 = 4'h1;
        y1 = 4'd6; fl_in1 = 4'b0000;
        press_hold1();
        btn1 = 1'b0;
        check("b_A", a1, 9);
        check("b_B", b1, 3);
        check("b_Cin", c1, 1);
        check("b_sh", sh1, 3);
        check("b_opq", opq1, 1);
        check("b_state", state1, 2);
        sb_q.push_back({24'd0, 4'b0000, 4'd6});
        wait_capture1(W1);

        // Sample point and ignored presses during S_WAIT
        press_hold1();
        check("show_to_a", state1, 0);
        release1();
        sw1 = 4'd7; press_hold1(); release1();
        sw1 = 4'd2; cin1 = 1'b0; op1 = 4'h3;
        press_hold1();
        btn1 = 1'b0;
        check("s2_state", state1, 2);
        sb_q.push_back({24'd0, 4'b0101, 4'hC});
        for (int i = 0; i < W1; i++) begin
            // Two button rises, acting on edges 5 and 8 after the B load.
            btn1   = (i == 2 || i == 3 || i == 5);
            y1     = (i == W1 - 1) ? 4'hC : N1'(i);
            fl_in1 = (i == W1 - 1) ? 4'b0101 : 4'b1010;
            step();
            if (i < W1 - 1) check("s2_wait_state", state1, 2);
        end
        btn1 = 1'b0;
        check("s2_done", done1, 1);
        check("s2_state_show", state1, 3);
        last_exp = sb_q.pop_front();
        check("s2_capture", {flags1, result1}, last_exp);
        check("s2_B_held", b1, 2);
        repeat (3) step();
        check("s2_no_queued", state1, 3);

        // Reset mid-operation at cnt=4
        press_hold1(); release1();
        sw1 = 4'd5; press_hold1(); release1();
        sw1 = 4'd2; cin1 = 1'b1; op1 = 4'h2;
        press_hold1();
        btn1 = 1'b0;
        repeat (4) step();
        check("mid_state", state1, 2);
        #3 rst1 = 1'b0;
        #1 check_zero1("async_rst");
        step();
        rst1 = 1'b1;
        repeat (3) step();
        sw1 = 4'd5; press_hold1(); release1();
        check("r_A", a1, 5);
        sw1 = 4'd2; cin1 = 1'b0; op1 = 4'h0;
        y1 = 4'd7; fl_in1 = 4'b0010;
        press_hold1();
        btn1 = 1'b0;
        check("r_B", b1, 2);
        sb_q.push_back({24'd0, 4'b0010, 4'd7});
        wait_capture1(W1);

        // Long press in S_SHOW
        a_keep = a1;
        sw1 = 4'hE;
        btn1 = 1'b1;
        trans = 0;
        prev_s = state1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (prev_s == 2'd3 && state1 == 2'd0) trans++;
            prev_s = state1;
        end
        check("lp_trans", trans, 1);
        check("lp_state", state1, 0);
        check("lp_A_kept", a1, a_keep);
        check("lp_hold", {flags1, result1}, last_exp);
        check("lp_done", done1, 0);
        release1();
        sw1 = 4'hA;
        press_hold1();
        check("lp_nextA", a1, 4'hA);
        check("lp_next_state", state1, 1);
        release1();

        // Parameter sweep: N=8, WAIT_CYCLES=1
        sw2 = 8'hF0;
        press_hold2();
        check("p_A", a2, 8'hF0);
        btn2 = 1'b0; repeat (3) step();
        sw2 = 8'h05; cin2 = 1'b1; op2 = 4'h6;
        press_hold2();
        btn2 = 1'b0;
        check("p_B", b2, 8'h05);
        check("p_sh", sh2, 4'h5);
        check("p_state", state2, 2);
        y2 = 8'h3C; fl_in2 = 4'b1001;
        sb_q.push_back({20'd0, 4'b1001, 8'h3C});
        step();
        check("p_done", done2, 1);
        check("p_state_show", state2, 3);
        last_exp = sb_q.pop_front();
        check("p_capture", {flags2, result2}, last_exp);
        step();
        check("p_done_clear", done2, 0);
        check("p_held", {flags2, result2}, last_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
